slc3_control_fsm: RTL and testbench
===================================

# slc3_control_fsm

Instruction-sequencing control unit for the SLC-3 datapath. Consumes the instruction words built with the shared SLC-3 opcode encoders once they are loaded into IR, and drives every register-load, bus-gate, mux-select, ALU and memory strobe for fetch, decode and execute. It is a Moore FSM with a programmable memory wait-state counter. It sits between IR/BEN and the datapath/SRAM interface.

## Interface
Parameters:
- MEM_WAIT, 2, number of cycles each memory read/write strobe is held; legal range 1..7.

Ports (Moore outputs, decoded from state only):
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  start execution from HALTED.
- Continue  in  1  resume from a pause instruction.
- Opcode  in  4  IR[15:12].
- IR_5  in  1  IR[5], the immediate select.
- IR_11  in  1  IR[11], the JSR flag.
- BEN  in  1  registered branch-enable from the datapath.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one is high in any state.
- PCMUX  out  2  PC source: 00 PC+1, 01 bus, 10 address adder.
- DRMUX  out  1  destination register: 0 IR[11:9], 1 R7.
- SR1MUX  out  1  SR1 field: 0 IR[11:9], 1 IR[8:6].
- SR2MUX  out  1  operand 2: 0 register, 1 sext(imm5).
- ADDR1MUX  out  1  adder base: 0 PC, 1 SR1.
- ADDR2MUX  out  2  adder offset: 00 zero, 01 off6, 10 off9, 11 off11.
- ALUK  out  2  ALU op: 00 ADD, 01 AND, 10 NOT, 11 PASSA.
- Mem_OE_n, Mem_WE_n  out  1 each  active-low SRAM strobes.

## Operation
- Reset (asynchronous, any time, including mid-instruction or mid-memory access):
  - State goes to HALTED and the wait counter clears.
  - All loads and gates are 0, all mux selects are 0, ALUK is 00, Mem_OE_n = Mem_WE_n = 1.
- HALTED: stay while Run = 0; go to FETCH1 when Run = 1. Run is ignored in every other state.
- Fetch:
  - FETCH1: GatePC, LD_MAR, PCMUX 00, LD_PC.
  - FETCH2: Mem_OE_n = 0, LD_MDR, held MEM_WAIT cycles.
  - FETCH3: GateMDR, LD_IR.
  - DECODE: LD_BEN, then dispatch on Opcode.
- Execute states:
  - ADD / AND / NOT: SR1MUX 1, SR2MUX = IR_5 (0 for NOT), ALUK 00 / 01 / 10, GateALU, DRMUX 0, LD_REG, LD_CC.
  - BR: BEN = 1 goes to BR_TAKEN; BEN = 0 goes to FETCH1. BR_TAKEN: ADDR1MUX 0, ADDR2MUX 10, PCMUX 10, LD_PC.
  - JMP: SR1MUX 1, ADDR1MUX 1, ADDR2MUX 00, PCMUX 10, LD_PC.
  - JSR: when IR_11 = 1, JSR1 does GatePC, DRMUX 1, LD_REG; then JSR2 does ADDR1MUX 0, ADDR2MUX 11, PCMUX 10, LD_PC. When IR_11 = 0 the instruction is a NOP and goes to FETCH1.
  - LDR: LDR1 does SR1MUX 1, ADDR1MUX 1, ADDR2MUX 01, GateMARMUX, LD_MAR. LDR2 is a memory read held MEM_WAIT cycles, same outputs as FETCH2. LDR3 does GateMDR, DRMUX 0, LD_REG, LD_CC.
  - STR: STR1 has the same outputs as LDR1. STR2 does SR1MUX 0, ALUK 11, GateALU, LD_MDR, Mem_OE_n = 1. STR3 drives Mem_WE_n = 0 for MEM_WAIT cycles.
  - PSE: PAUSE1 asserts LD_LED every cycle and stays while Continue = 0; Continue = 1 goes to PAUSE2. PAUSE2 stays while Continue = 1; Continue = 0 goes to FETCH1.
- Any undefined opcode executes as a NOP: DECODE goes straight to FETCH1.
- Every execute path ends in FETCH1.

## Timing
- Wait counter:
  - Width is 3 bits. It loads 0 on entry to FETCH2, LDR2 or STR3 and increments each cycle in those states.
  - The state exits when the counter equals MEM_WAIT-1, so each of those states is occupied for exactly MEM_WAIT cycles.
- Instruction lengths, counted from FETCH1 to the next FETCH1 (let W = MEM_WAIT):
  - ADD/AND/NOT, not-taken BR, JMP: W+4 cycles.
  - Taken BR, JSR: W+5 cycles.
  - STR: 2W+5 cycles.
  - LDR: W+5 plus another W.
  - PSE: W+3 plus the Continue handshake.
- From Run = 1 sampled in HALTED to FETCH1 outputs is 1 edge.
- The strobes are never low together, and neither is low outside FETCH2, LDR2 or STR3.

## Structure
- Add to the shared SLC-3 package:
  - the state enum type;
  - the PCMUX, ADDR2MUX and ALUK encoding constants;
  - the MEM_WAIT range check.
- Sub-module: slc3_mem_wait_counter, containing the counter and its done flag.
- The FSM is one state register, one next-state block and one output-decode block.

## Test plan
- Reset and start: hold Reset_n = 0 for 3 cycles, then Run = 1 → 1 edge to FETCH1 (GatePC = LD_MAR = LD_PC = 1); with MEM_WAIT = 2, Mem_OE_n is low for exactly 2 cycles.
- ADD immediate: Opcode 0001, IR_5 = 1 → after DECODE, one cycle with GateALU, LD_REG, LD_CC, SR2MUX = 1, ALUK = 00; total 6 cycles.
- Branch both ways: Opcode 0000 with BEN = 0 → FETCH1 after BR; with BEN = 1 → BR_TAKEN with PCMUX = 10, ADDR2MUX = 10.
- STR then LDR with MEM_WAIT = 3:
  - STR: Mem_WE_n low for exactly 3 cycles, Mem_OE_n high throughout.
  - LDR: LD_REG asserted once, in LDR3.
- Pause handshake: Opcode 1101 with Continue held 0 for 10 cycles → LD_LED high all 10; Continue pulsed 1 for 4 cycles then 0 → FETCH1 only after the fall.
- Reset mid-access: assert Reset_n = 0 during STR3 → Mem_WE_n = 1 and all loads 0 in the same cycle, no clock edge needed; then JSR with IR_11 = 0 → NOP path, R7 not written.

Source files
------------

// File: rtl/slc3_control_fsm_pkg.sv
// Shared SLC-3 control definitions: FSM state type, datapath select encodings,
// opcodes and the legal range of the memory wait-state count.
package slc3_control_fsm_pkg;

  typedef enum logic [4:0] {
    S_HALTED,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR,
    S_BR_TAKEN,
    S_JMP,
    S_JSR1,
    S_JSR2,
    S_LDR1,
    S_LDR2,
    S_LDR3,
    S_STR1,
    S_STR2,
    S_STR3,
    S_PAUSE1,
    S_PAUSE2
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam int unsigned MEM_WAIT_MIN = 1;
  localparam int unsigned MEM_WAIT_MAX = 7;

  function automatic bit mem_wait_legal(input int unsigned w);
    return (w >= MEM_WAIT_MIN) && (w <= MEM_WAIT_MAX);
  endfunction

endpackage

// File: rtl/slc3_mem_wait_counter.sv
// Memory wait-state counter: runs while the FSM sits in a memory-strobe state
// and flags the last cycle of the MEM_WAIT-cycle hold.
module slc3_mem_wait_counter #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  output logic done_o
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] cnt_q, cnt_d;

  assign done_o = active_i && (cnt_q == LAST);

  // Clearing on the final cycle and whenever idle guarantees 0 on entry.
  always_comb begin
    cnt_d = '0;
    if (active_i && !done_o) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/slc3_control_fsm.sv
// SLC-3 instruction-sequencing control unit: Moore FSM driving datapath loads,
// bus gates, mux selects, ALU op and SRAM strobes for fetch/decode/execute.
module slc3_control_fsm
  import slc3_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE_n,
  output logic       Mem_WE_n
);

  if (!mem_wait_legal(MEM_WAIT)) begin : g_bad_mem_wait
    $fatal(1, "slc3_control_fsm: MEM_WAIT out of range 1..7");
  end

  state_e state_q, state_d;
  logic   wait_active;
  logic   wait_done;

  assign wait_active = (state_q == S_FETCH2) || (state_q == S_LDR2) ||
                       (state_q == S_STR3);

  slc3_mem_wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .active_i (wait_active),
    .done_o   (wait_done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALTED:   if (Run) state_d = S_FETCH1;
      S_FETCH1:   state_d = S_FETCH2;
      S_FETCH2:   if (wait_done) state_d = S_FETCH3;
      S_FETCH3:   state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD:  state_d = S_ADD;
          OP_AND:  state_d = S_AND;
          OP_NOT:  state_d = S_NOT;
          OP_BR:   state_d = S_BR;
          OP_JMP:  state_d = S_JMP;
          OP_JSR:  state_d = IR_11 ? S_JSR1 : S_FETCH1;
          OP_LDR:  state_d = S_LDR1;
          OP_STR:  state_d = S_STR1;
          OP_PSE:  state_d = S_PAUSE1;
          default: state_d = S_FETCH1;
        endcase
      end
      S_BR:       state_d = BEN ? S_BR_TAKEN : S_FETCH1;
      S_JSR1:     state_d = S_JSR2;
      S_LDR1:     state_d = S_LDR2;
      S_LDR2:     if (wait_done) state_d = S_LDR3;
      S_STR1:     state_d = S_STR2;
      S_STR2:     state_d = S_STR3;
      S_STR3:     if (wait_done) state_d = S_FETCH1;
      S_PAUSE1:   if (Continue) state_d = S_PAUSE2;
      S_PAUSE2:   if (!Continue) state_d = S_FETCH1;
      S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR2, S_LDR3:
                  state_d = S_FETCH1;
      default:    state_d = S_HALTED;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC1;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALUK_ADD;
    Mem_OE_n   = 1'b1;
    Mem_WE_n   = 1'b1;
    case (state_q)
      S_FETCH1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        PCMUX  = PCMUX_PC1;
        LD_PC  = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        Mem_OE_n = 1'b0;
        LD_MDR   = 1'b1;
      end
      S_FETCH3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        SR1MUX  = 1'b1;
        SR2MUX  = (state_q == S_NOT) ? 1'b0 : IR_5;
        ALUK    = (state_q == S_ADD) ? ALUK_ADD :
                  (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_BR_TAKEN: begin
        ADDR2MUX = ADDR2_OFF9;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
      end
      S_JMP: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
      end
      S_JSR1: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_JSR2: begin
        ADDR2MUX = ADDR2_OFF11;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
      end
      S_LDR1, S_STR1: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_OFF6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_LDR3: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_STR2: begin
        ALUK    = ALUK_PASSA;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_STR3:   Mem_WE_n = 1'b0;
      S_PAUSE1: LD_LED   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_slc3_control_fsm.sv
// Directed bench for slc3_control_fsm: per-cycle expected output vectors are
// queued per instruction and popped/compared as the FSM steps through them.
module tb_slc3_control_fsm;

  localparam logic [23:0] M_LD_MAR   = 24'h800000;
  localparam logic [23:0] M_LD_MDR   = 24'h400000;
  localparam logic [23:0] M_LD_IR    = 24'h200000;
  localparam logic [23:0] M_LD_BEN   = 24'h100000;
  localparam logic [23:0] M_LD_CC    = 24'h080000;
  localparam logic [23:0] M_LD_REG   = 24'h040000;
  localparam logic [23:0] M_LD_PC    = 24'h020000;
  localparam logic [23:0] M_LD_LED   = 24'h010000;
  localparam logic [23:0] M_GPC      = 24'h008000;
  localparam logic [23:0] M_GMDR     = 24'h004000;
  localparam logic [23:0] M_GALU     = 24'h002000;
  localparam logic [23:0] M_GMARMUX  = 24'h001000;
  localparam logic [23:0] M_PCMUX_AD = 24'h000800;
  localparam logic [23:0] M_DRMUX    = 24'h000200;
  localparam logic [23:0] M_SR1MUX   = 24'h000100;
  localparam logic [23:0] M_SR2MUX   = 24'h000080;
  localparam logic [23:0] M_ADDR1MUX = 24'h000040;
  localparam logic [23:0] M_A2_OFF6  = 24'h000010;
  localparam logic [23:0] M_A2_OFF9  = 24'h000020;
  localparam logic [23:0] M_A2_OFF11 = 24'h000030;
  localparam logic [23:0] M_ALUK_AND = 24'h000004;
  localparam logic [23:0] M_ALUK_NOT = 24'h000008;
  localparam logic [23:0] M_ALUK_PA  = 24'h00000C;
  localparam logic [23:0] M_OE_N     = 24'h000002;
  localparam logic [23:0] M_WE_N     = 24'h000001;

  localparam logic [23:0] V_IDLE  = M_OE_N | M_WE_N;
  localparam logic [23:0] V_F1    = V_IDLE | M_GPC | M_LD_MAR | M_LD_PC;
  localparam logic [23:0] V_MRD   = M_WE_N | M_LD_MDR;
  localparam logic [23:0] V_F3    = V_IDLE | M_GMDR | M_LD_IR;
  localparam logic [23:0] V_DEC   = V_IDLE | M_LD_BEN;
  localparam logic [23:0] V_ALU   = V_IDLE | M_SR1MUX | M_GALU | M_LD_REG | M_LD_CC;
  localparam logic [23:0] V_BRT   = V_IDLE | M_A2_OFF9 | M_PCMUX_AD | M_LD_PC;
  localparam logic [23:0] V_JMP   = V_IDLE | M_SR1MUX | M_ADDR1MUX | M_PCMUX_AD | M_LD_PC;
  localparam logic [23:0] V_JSR1  = V_IDLE | M_GPC | M_DRMUX | M_LD_REG;
  localparam logic [23:0] V_JSR2  = V_IDLE | M_A2_OFF11 | M_PCMUX_AD | M_LD_PC;
  localparam logic [23:0] V_MADDR = V_IDLE | M_SR1MUX | M_ADDR1MUX | M_A2_OFF6 | M_GMARMUX | M_LD_MAR;
  localparam logic [23:0] V_LDR3  = V_IDLE | M_GMDR | M_LD_REG | M_LD_CC;
  localparam logic [23:0] V_STR2  = V_IDLE | M_ALUK_PA | M_GALU | M_LD_MDR;
  localparam logic [23:0] V_STR3  = M_OE_N;
  localparam logic [23:0] V_P1    = V_IDLE | M_LD_LED;

  typedef struct {
    string       tag;
    logic [23:0] v;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  logic       Clk;
  logic       Reset_n, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic       sel;

  logic       a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_ben, a_ld_cc, a_ld_reg, a_ld_pc, a_ld_led;
  logic       a_gpc, a_gmdr, a_galu, a_gmarmux, a_drmux, a_sr1mux, a_sr2mux, a_addr1mux;
  logic       a_oe_n, a_we_n;
  logic [1:0] a_pcmux, a_addr2mux, a_aluk;
  logic       b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_ben, b_ld_cc, b_ld_reg, b_ld_pc, b_ld_led;
  logic       b_gpc, b_gmdr, b_galu, b_gmarmux, b_drmux, b_sr1mux, b_sr2mux, b_addr1mux;
  logic       b_oe_n, b_we_n;
  logic [1:0] b_pcmux, b_addr2mux, b_aluk;

  logic [23:0] obs_a, obs_b, obs;

  assign obs_a = {a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_ben, a_ld_cc, a_ld_reg, a_ld_pc, a_ld_led,
                  a_gpc, a_gmdr, a_galu, a_gmarmux, a_pcmux, a_drmux, a_sr1mux, a_sr2mux,
                  a_addr1mux, a_addr2mux, a_aluk, a_oe_n, a_we_n};
  assign obs_b = {b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_ben, b_ld_cc, b_ld_reg, b_ld_pc, b_ld_led,
                  b_gpc, b_gmdr, b_galu, b_gmarmux, b_pcmux, b_drmux, b_sr1mux, b_sr2mux,
                  b_addr1mux, b_addr2mux, b_aluk, b_oe_n, b_we_n};
  assign obs = sel ? obs_b : obs_a;

  slc3_control_fsm #(.MEM_WAIT(2)) dut_w2 (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(a_ld_mar), .LD_MDR(a_ld_mdr), .LD_IR(a_ld_ir), .LD_BEN(a_ld_ben),
    .LD_CC(a_ld_cc), .LD_REG(a_ld_reg), .LD_PC(a_ld_pc), .LD_LED(a_ld_led),
    .GatePC(a_gpc), .GateMDR(a_gmdr), .GateALU(a_galu), .GateMARMUX(a_gmarmux),
    .PCMUX(a_pcmux), .DRMUX(a_drmux), .SR1MUX(a_sr1mux), .SR2MUX(a_sr2mux),
    .ADDR1MUX(a_addr1mux), .ADDR2MUX(a_addr2mux), .ALUK(a_aluk),
    .Mem_OE_n(a_oe_n), .Mem_WE_n(a_we_n)
  );

  slc3_control_fsm #(.MEM_WAIT(3)) dut_w3 (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(b_ld_mar), .LD_MDR(b_ld_mdr), .LD_IR(b_ld_ir), .LD_BEN(b_ld_ben),
    .LD_CC(b_ld_cc), .LD_REG(b_ld_reg), .LD_PC(b_ld_pc), .LD_LED(b_ld_led),
    .GatePC(b_gpc), .GateMDR(b_gmdr), .GateALU(b_galu), .GateMARMUX(b_gmarmux),
    .PCMUX(b_pcmux), .DRMUX(b_drmux), .SR1MUX(b_sr1mux), .SR2MUX(b_sr2mux),
    .ADDR1MUX(b_addr1mux), .ADDR2MUX(b_addr2mux), .ALUK(b_aluk),
    .Mem_OE_n(b_oe_n), .Mem_WE_n(b_we_n)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected summary before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic push_n(input string tag, input logic [23:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push(tag, v);
  endtask

  task automatic push_fetch(input int unsigned w);
    push("fetch1", V_F1);
    push_n("fetch2", V_MRD, w);
    push("fetch3", V_F3);
    push("decode", V_DEC);
  endtask

  task automatic check_now();
    exp_t e;
    e = sbq.pop_front();
    n_checks++;
    assert (obs === e.v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %06h expected %06h", e.tag, obs, e.v);
    end
  endtask

  task automatic drain();
    while (sbq.size() > 0) begin
      check_now();
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    sel = 1'b0; Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

    // MEM_WAIT = 2 instance
    repeat (3) @(posedge Clk);
    #1;
    push("reset", V_IDLE);
    check_now();
    Reset_n = 1'b1;
    push_n("halted_wait", V_IDLE, 2);
    drain();
    Run = 1'b1;
    push("halted_run", V_IDLE);
    drain();
    Run = 1'b0;

    Opcode = 4'b0001; IR_5 = 1'b1;
    push_fetch(2); push("add_imm", V_ALU | M_SR2MUX);
    drain();
    Opcode = 4'b0101; IR_5 = 1'b0;
    push_fetch(2); push("and_reg", V_ALU | M_ALUK_AND);
    drain();
    Opcode = 4'b1001; IR_5 = 1'b1;
    push_fetch(2); push("not", V_ALU | M_ALUK_NOT);
    drain();
    Opcode = 4'b0000; BEN = 1'b0;
    push_fetch(2); push("br_nt", V_IDLE);
    drain();
    BEN = 1'b1;
    push_fetch(2); push("br_t", V_IDLE); push("br_taken", V_BRT);
    drain();
    BEN = 1'b0;
    Opcode = 4'b1100;
    push_fetch(2); push("jmp", V_JMP);
    drain();
    Opcode = 4'b0100; IR_11 = 1'b1;
    push_fetch(2); push("jsr1", V_JSR1); push("jsr2", V_JSR2);
    drain();
    IR_11 = 1'b0;
    Opcode = 4'b1101; Continue = 1'b0;
    push_fetch(2); push_n("pause1_hold", V_P1, 10);
    drain();
    Continue = 1'b1;
    push("pause1_cont", V_P1); push_n("pause2_hold", V_IDLE, 3);
    drain();
    Continue = 1'b0;
    push("pause2_fall", V_IDLE);
    drain();
    Opcode = 4'b1000;
    push_fetch(2);
    drain();
    Opcode = 4'b0001; IR_5 = 1'b0;
    push("undef_to_fetch1", V_F1);
    drain();

    // MEM_WAIT = 3 instance
    Reset_n = 1'b0;
    #1;
    sel = 1'b1;
    push("reset_w3", V_IDLE);
    check_now();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    Run = 1'b1;
    push("halted_run_w3", V_IDLE);
    drain();
    Run = 1'b0;

    Opcode = 4'b0111;
    push_fetch(3); push("str1", V_MADDR); push("str2", V_STR2); push_n("str3", V_STR3, 3);
    drain();
    Opcode = 4'b0110;
    push_fetch(3); push("ldr1", V_MADDR); push_n("ldr2", V_MRD, 3); push("ldr3", V_LDR3);
    drain();
    Opcode = 4'b0111;
    push_fetch(3); push("str1b", V_MADDR); push("str2b", V_STR2); push("str3b", V_STR3);
    drain();
    push("str3_mid", V_STR3);
    check_now();
    #2;
    Reset_n = 1'b0;
    #1;
    push("reset_mid_access", V_IDLE);
    check_now();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    Run = 1'b1;
    push("halted_after_mid", V_IDLE);
    drain();
    Run = 1'b0;
    Opcode = 4'b0100; IR_11 = 1'b0;
    push_fetch(3); push("jsr_nop_fetch1", V_F1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
